bus_timer_slave: RTL

- Memory-mapped timer that sits on the slave (responder) end of the SoC Bus interface (valid/instr/ready/addr/wdata/wstrb/rdata).
- Provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and a level interrupt output.
- Instantiated behind the system address decoder alongside RAM and other peripherals; answers only accesses inside its address window.

---
 rtl/bus_timer_slave_pkg.sv | 26 ++
 rtl/bus_slave_ctrl.sv | 77 +++++++
 rtl/bus_timer_slave.sv | 102 ++++++++++
 3 files changed

// File: rtl/bus_timer_slave_pkg.sv
// Shared definitions for Bus slaves: register offsets of the timer,
// CTRL bit positions, the generic slave FSM state and a byte-lane merge helper.
package bus_timer_slave_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} slv_state_e;

   localparam logic [31:0] TIMER_CTRL     = 32'h00;
   localparam logic [31:0] TIMER_PRESCALE = 32'h04;
   localparam logic [31:0] TIMER_COUNT    = 32'h08;
   localparam logic [31:0] TIMER_COMPARE  = 32'h0C;
   localparam logic [31:0] TIMER_STATUS   = 32'h10;

   localparam int CTRL_EN = 0;
   localparam int CTRL_AR = 1;
   localparam int CTRL_IE = 2;

   function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  ws);
      logic [31:0] m;
      for (int i = 0; i < 4; i++)
         m[8*i +: 8] = ws[i] ? wd[8*i +: 8] : old[8*i +: 8];
      return m;
   endfunction

endpackage

// File: rtl/bus_slave_ctrl.sv
// Generic Bus slave front end: window decode, IDLE/WAIT/ACK sequencing,
// request latching, one-cycle commit strobe and registered read data.
module bus_slave_ctrl
   import bus_timer_slave_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          ADDR_BITS   = 5,
   parameter int          WAIT_STATES = 0
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 valid,
   input  logic [31:0]          addr,
   input  logic [31:0]          wdata,
   input  logic [3:0]           wstrb,
   input  logic [31:0]          rdata_next,
   output logic                 ready,
   output logic [31:0]          rdata,
   output logic                 commit,
   output logic [ADDR_BITS-1:0] offset,
   output logic [ADDR_BITS-1:0] roffset,
   output logic [31:0]          cwdata,
   output logic [3:0]           cwstrb
);

   localparam logic [3:0] WLOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   slv_state_e state, state_d;
   logic [3:0] wcnt;
   logic       hit;

   assign hit = valid && (addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);

   // With no wait states the read mux must look at the live address,
   // because the latched copy only exists from the ACK cycle on.
   assign roffset = (state == IDLE) ? addr[ADDR_BITS-1:0] : offset;

   always_comb begin
      state_d = state;
      ready   = 1'b0;
      commit  = 1'b0;
      case (state)
         IDLE: if (hit) state_d = (WAIT_STATES == 0) ? ACK : WAIT;
         WAIT: if (wcnt == 4'd0) state_d = ACK;
         ACK: begin
            ready   = 1'b1;
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         wcnt   <= 4'd0;
         offset <= '0;
         cwdata <= 32'd0;
         cwstrb <= 4'd0;
         rdata  <= 32'd0;
      end else begin
         state <= state_d;
         if (state == IDLE && hit) begin
            offset <= addr[ADDR_BITS-1:0];
            cwdata <= wdata;
            cwstrb <= wstrb;
            wcnt   <= WLOAD;
         end else if (state == WAIT && wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
         end
         if (state_d == ACK && state != ACK)
            rdata <= rdata_next;
      end
   end

endmodule

// File: rtl/bus_timer_slave.sv
// Memory-mapped prescaled 32-bit timer with compare, sticky match flag
// and a registered level interrupt, answering on its Bus address window.
module bus_timer_slave
   import bus_timer_slave_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          ADDR_BITS   = 5,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid,
   input  logic        instr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        irq
);

   logic                 commit, wr, tick, cmp_hit;
   logic [ADDR_BITS-1:0] offset, roffset;
   logic [31:0]          cwdata, rdata_next, woff, roff;
   logic [3:0]           cwstrb;
   logic                 en, ar, ie, match;
   logic [15:0]          presc, pcnt;
   logic [31:0]          count, compare, count_m, compare_m;
   logic                 unused_instr;

   assign unused_instr = instr;

   bus_slave_ctrl #(
      .BASE_ADDR(BASE_ADDR), .ADDR_BITS(ADDR_BITS), .WAIT_STATES(WAIT_STATES)
   ) u_ctrl (
      .clk(clk), .resetn(resetn), .valid(valid), .addr(addr), .wdata(wdata),
      .wstrb(wstrb), .rdata_next(rdata_next), .ready(ready), .rdata(rdata),
      .commit(commit), .offset(offset), .roffset(roffset), .cwdata(cwdata),
      .cwstrb(cwstrb)
   );

   assign wr        = commit && (cwstrb != 4'd0);
   assign woff      = 32'(offset) & ~32'h3;
   assign roff      = 32'(roffset) & ~32'h3;
   assign tick      = en && (pcnt == presc);
   assign cmp_hit   = tick && (count == compare);
   assign count_m   = byte_merge(count, cwdata, cwstrb);
   assign compare_m = byte_merge(compare, cwdata, cwstrb);

   always_comb begin
      rdata_next = 32'd0;
      case (roff)
         TIMER_CTRL:     rdata_next = {29'd0, ie, ar, en};
         TIMER_PRESCALE: rdata_next = {16'd0, presc};
         TIMER_COUNT:    rdata_next = count;
         TIMER_COMPARE:  rdata_next = compare;
         TIMER_STATUS:   rdata_next = {31'd0, match};
         default:        rdata_next = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         en      <= 1'b0;
         ar      <= 1'b0;
         ie      <= 1'b0;
         presc   <= 16'd0;
         pcnt    <= 16'd0;
         count   <= 32'd0;
         compare <= 32'd0;
         match   <= 1'b0;
         irq     <= 1'b0;
      end else begin
         pcnt <= (!en || tick) ? 16'd0 : pcnt + 16'd1;
         if (tick)
            count <= (cmp_hit && ar) ? 32'd0 : count + 32'd1;
         // Bus writes come after the tick update so a COUNT write wins.
         if (wr) begin
            case (woff)
               TIMER_CTRL: if (cwstrb[0]) begin
                  en <= cwdata[CTRL_EN];
                  ar <= cwdata[CTRL_AR];
                  ie <= cwdata[CTRL_IE];
               end
               TIMER_PRESCALE: begin
                  if (cwstrb[0]) presc[7:0]  <= cwdata[7:0];
                  if (cwstrb[1]) presc[15:8] <= cwdata[15:8];
               end
               TIMER_COUNT:   count   <= count_m;
               TIMER_COMPARE: compare <= compare_m;
               default: ;
            endcase
         end
         if (cmp_hit)
            match <= 1'b1;
         else if (wr && woff == TIMER_STATUS && cwstrb[0] && cwdata[0])
            match <= 1'b0;
         irq <= match & ie;
      end
   end

endmodule
